// File: rtl/hamming_enc_engine.sv
// rtl/hamming_enc_engine.sv - SECDED Hamming encoder engine for the data-memory port
//
// Reads NUM_MSG 11-bit messages from SRC_BASE (lo byte, then hi[2:0]) and writes
// 16-bit codewords {d[11:5],p8,d[4:2],p4,d[1],p2,p1,p0} to DST_BASE (lo byte first).
// Five cycles per message: RD_LO, RD_HI, CALC, WR_LO, WR_HI; one FIN cycle per run.
//
// Ports:
//   clk        system clock, all state on posedge
//   reset      asynchronous active-high reset
//   start      run request, sampled only in IDLE
//   inj_en     single-bit error injection enable (HAMMING_ENC_INJECT_EN only)
//   inj_pos    codeword bit to flip when injecting (HAMMING_ENC_INJECT_EN only)
//   busy       run in progress (memory granted to the engine)
//   done       sticky completion flag, cleared by reset or the next accepted start
//   mem_addr   memory address (read or write)
//   mem_rdata  read data, valid the cycle after mem_addr
//   mem_wdata  write data
//   mem_we     byte write strobe
//
// Optional feature macro: HAMMING_ENC_INJECT_EN (adds inj_en/inj_pos).

module hamming_enc_engine #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
`ifdef HAMMING_ENC_INJECT_EN
  input  logic          inj_en,
  input  logic [3:0]    inj_pos,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    mem_wdata,
  output logic          mem_we
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CALC, WR_LO, WR_HI, FIN} state_t;

  localparam logic [6:0] LAST_IDX = 7'(NUM_MSG - 1);

  state_t        state, state_nxt;
  logic [6:0]    idx;
  logic [7:0]    lo_q;
  logic [15:0]   cw_q;
  logic [11:1]   d;
  logic          p8, p4, p2, p1, p0;
  logic [15:0]   cw, cw_out;
  logic          last;
  logic [AW-1:0] src_addr, dst_addr;

  assign last     = (idx == LAST_IDX);
  // Address arithmetic wraps modulo 2^AW.
  assign src_addr = AW'(SRC_BASE) + AW'({idx, 1'b0});
  assign dst_addr = AW'(DST_BASE) + AW'({idx, 1'b0});

  // In CALC mem_rdata holds the hi byte; only its low 3 bits carry data.
  always_comb begin
    d  = {mem_rdata[2:0], lo_q};
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = ^{d[11], d[10], d[7], d[6], d[4], d[3], d[1]};
    p1 = ^{d[11], d[9], d[7], d[5], d[4], d[2], d[1]};
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
    cw = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  end

`ifdef HAMMING_ENC_INJECT_EN
  // Parity above is always taken from clean data; the flip is applied afterwards.
  assign cw_out = inj_en ? (cw ^ (16'b1 << inj_pos)) : cw;
`else
  assign cw_out = cw;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      lo_q  <= '0;
      cw_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          idx  <= '0;
          done <= 1'b0;
          busy <= 1'b1;
        end
        RD_HI: lo_q <= mem_rdata;
        CALC:  cw_q <= cw_out;
        WR_HI: if (!last) idx <= idx + 7'd1;
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Memory outputs decode straight from state, so a reset drops mem_we immediately.
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE:  if (start) state_nxt = RD_LO;
      RD_LO: begin
        mem_addr  = src_addr;
        state_nxt = RD_HI;
      end
      RD_HI: begin
        mem_addr  = src_addr + AW'(1);
        state_nxt = CALC;
      end
      CALC:  state_nxt = WR_LO;
      WR_LO: begin
        mem_we    = 1'b1;
        mem_addr  = dst_addr;
        mem_wdata = cw_q[7:0];
        state_nxt = WR_HI;
      end
      WR_HI: begin
        mem_we    = 1'b1;
        mem_addr  = dst_addr + AW'(1);
        mem_wdata = cw_q[15:8];
        state_nxt = last ? FIN : RD_LO;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// tb/tb_hamming_enc_engine.sv - randomized self-checking bench for hamming_enc_engine

module tb_hamming_enc_engine;

  localparam int NMSG = 15;
  localparam int DST  = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, mem_we;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;
`ifdef HAMMING_ENC_INJECT_EN
  logic       inj_en = 1'b0;
  logic [3:0] inj_pos = 4'd0;
`endif

  logic [7:0]  mem [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_addr = 8'd0, tb_wdata = 8'd0;
  int          wr_cnt = 0, bad_wr = 0;

  logic [10:0] cur_msg [NMSG];
  logic [7:0]  src_img [2*NMSG];
  int          checks = 0, errors = 0;
  int          cyc;

  always #5 clk = ~clk;

  hamming_enc_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
`ifdef HAMMING_ENC_INJECT_EN
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
`endif
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  // 1-cycle synchronous-read memory with a bench backdoor write port.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      if (mem_addr < 8'(DST) || mem_addr > 8'(DST + 2*NMSG - 1)) bad_wr <= bad_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Classic Hamming placement: data fills non-power-of-two positions 3,5,6,7,9..15 in
  // order, parity at 2^k covers every position with bit k set, bit 0 is overall parity.
  function automatic logic [15:0] ref_cw(input logic [10:0] m);
    logic [15:0] c;
    int k;
    logic par;
    c = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = m[k];
        k++;
      end
    for (int p = 1; p < 16; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & p) != 0 && pos != p) par = par ^ c[pos];
      c[p] = par;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_wdata = v;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Writes cur_msg into the source region and marks the destination with 8'h5A.
  task automatic load(input bit hi_ones);
    logic [7:0] hi;
    for (int i = 0; i < NMSG; i++) begin
      hi = {hi_ones ? 5'h1F : 5'h00, cur_msg[i][10:8]};
      src_img[2*i]   = cur_msg[i][7:0];
      src_img[2*i+1] = hi;
      poke(8'(2*i), cur_msg[i][7:0]);
      poke(8'(2*i+1), hi);
    end
    for (int i = 0; i < 2*NMSG; i++) poke(8'(DST + i), 8'h5A);
  endtask

  task automatic rand_msgs();
    for (int i = 0; i < NMSG; i++) cur_msg[i] = 11'($urandom);
  endtask

  task automatic verify(input string tag, input logic [15:0] flip);
    for (int i = 0; i < NMSG; i++)
      check($sformatf("%s_cw%0d", tag, i), 32'({mem[DST+2*i+1], mem[DST+2*i]}),
            32'(ref_cw(cur_msg[i]) ^ flip));
    for (int i = 0; i < 2*NMSG; i++)
      check($sformatf("%s_src%0d", tag, i), 32'(mem[i]), 32'(src_img[i]));
  endtask

  // Starts a run; optionally re-pulses start at cycle pulse_at or resets at cycle reset_at.
  task automatic run(input string tag, input int pulse_at, input int reset_at, output int cycles);
    int wr0, busy_gap;
    bit stop;
    wr0 = wr_cnt;
    busy_gap = 0;
    stop = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_accept_busy"}, 32'(busy), 32'd1);
    check({tag, "_accept_done_clr"}, 32'(done), 32'd0);
    cycles = 0;
    while (!stop) begin
      start = (cycles + 1 == pulse_at);
      @(posedge clk);
      cycles++;
      #1;
      if (cycles == reset_at) begin
        check({tag, "_pre_reset_we"}, 32'(mem_we), 32'd1);
        #2 reset = 1'b1;
        #1;
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_done"}, 32'(done), 32'd0);
        check({tag, "_rst_we"}, 32'(mem_we), 32'd0);
        start = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 check({tag, "_rst_writes"}, 32'(wr_cnt - wr0), 32'd12);
        stop = 1'b1;
      end else if (done) begin
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(2*NMSG));
        check({tag, "_busy_held"}, 32'(busy_gap), 32'd0);
        stop = 1'b1;
      end else begin
        if (!busy) busy_gap++;
        if (cycles >= 400) begin
          check({tag, "_timeout"}, 32'(cycles), 32'(5*NMSG+1));
          stop = 1'b1;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

    // All-zero messages
    for (int i = 0; i < NMSG; i++) cur_msg[i] = 11'h000;
    load(1'b0);
    run("zero", 0, 0, cyc);
    check("zero_latency", 32'(cyc), 32'(5*NMSG+1));
    verify("zero", 16'h0000);
    @(posedge clk);
    #1 check("done_sticky", 32'(done), 32'd1);

    // Fixed corner messages
    rand_msgs();
    cur_msg[0] = 11'h7FF; cur_msg[1] = 11'h001; cur_msg[2] = 11'h400;
    load(1'b0);
    run("fixed", 0, 0, cyc);
    check("fixed_7ff", 32'({mem[DST+1], mem[DST]}), 32'h0000FFFF);
    check("fixed_001", 32'({mem[DST+3], mem[DST+2]}), 32'h0000000F);
    check("fixed_400", 32'({mem[DST+5], mem[DST+4]}), 32'h00008117);
    verify("fixed", 16'h0000);

    // Random messages, hi byte junk bits set
    for (int r = 0; r < 3; r++) begin
      rand_msgs();
      load(1'b1);
      run($sformatf("rand%0d", r), 0, 0, cyc);
      check($sformatf("rand%0d_latency", r), 32'(cyc), 32'(5*NMSG+1));
      verify($sformatf("rand%0d", r), 16'h0000);
    end

    // Start re-pulsed mid-run
    rand_msgs();
    load(1'b0);
    run("restart", 20, 0, cyc);
    check("restart_latency", 32'(cyc), 32'(5*NMSG+1));
    verify("restart", 16'h0000);

    // Reset during WR_LO of message 6
    rand_msgs();
    load(1'b0);
    run("midrst", 0, 33, cyc);
    check("midrst_cw5", 32'({mem[DST+11], mem[DST+10]}), 32'(ref_cw(cur_msg[5])));
    check("midrst_no_partial", 32'(mem[DST+12]), 32'h5A);
    check("midrst_untouched", 32'(mem[DST+13]), 32'h5A);
    run("after_rst", 0, 0, cyc);
    check("after_rst_latency", 32'(cyc), 32'(5*NMSG+1));
    verify("after_rst", 16'h0000);

`ifdef HAMMING_ENC_INJECT_EN
    rand_msgs();
    cur_msg[0] = 11'h400;
    load(1'b0);
    inj_en = 1'b1;
    inj_pos = 4'd8;
    run("inject", 0, 0, cyc);
    inj_en = 1'b0;
    check("inject_400", 32'({mem[DST+1], mem[DST]}), 32'h00008017);
    verify("inject", 16'h0100);
`endif

    check("stray_writes", 32'(bad_wr), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
